// File: rtl/level_pkg.sv
// Shared definitions for the level controller.
// Contents: fill-state enumeration, level width and the top fill level.
package level_pkg;

    localparam int LEVEL_W = 3;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } level_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter and
// rising-edge detector producing one pulse per accepted press.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   btn    in   raw button, asynchronous, may bounce
//   press  out  single-cycle pulse when the debounced state goes 0->1
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             db_state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            db_state <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability filter
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            // debounce: count consecutive cycles of disagreement, any agreement restarts
            if (sync_p1 != db_state) begin
                if (cnt == CNT_LAST) begin
                    db_state <= sync_p1;
                    cnt      <= '0;
                    // only the 0->1 transition is an event
                    press    <= sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/level_ctrl.sv
// Fill-level controller: two debounced buttons step a saturating 0..7
// level; flags full/empty, pulses err on rejected requests and blinks
// while full.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   inc_btn  in   raw "add one" button
//   dec_btn  in   raw "remove one" button
//   level    out  current level 0..7
//   full     out  level is 7
//   empty    out  level is 0
//   err      out  one-cycle pulse on rejected overflow/underflow
//   blink    out  blink enable, toggles only while full
module level_ctrl
    import level_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_btn,
    input  logic               dec_btn,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty,
    output logic               err,
    output logic               blink
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE   = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_BELOW = LEVEL_MAX - LEVEL_ONE;

    function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] l);
        return (l == LEVEL_MAX) ? l : l + LEVEL_ONE;
    endfunction

    function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] l);
        return (l == '0) ? l : l - LEVEL_ONE;
    endfunction

    logic         inc_evt;
    logic         dec_evt;
    logic         inc_only;
    logic         dec_only;
    level_state_t state;
    logic [BW-1:0] blink_cnt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (inc_btn),
        .press (inc_evt)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dec_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (dec_btn),
        .press (dec_evt)
    );

    // simultaneous requests cancel each other
    assign inc_only = inc_evt & ~dec_evt;
    assign dec_only = dec_evt & ~inc_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            err       <= 1'b0;
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                EMPTY: begin
                    if (inc_only) begin
                        level <= sat_inc(level);
                        state <= PARTIAL;
                        empty <= 1'b0;
                    end else if (dec_only) begin
                        err <= 1'b1;
                    end
                end
                PARTIAL: begin
                    if (inc_only) begin
                        level <= sat_inc(level);
                        if (level == LEVEL_BELOW) begin
                            // blink restarts from a known phase on every FULL entry
                            state     <= FULL;
                            full      <= 1'b1;
                            blink     <= 1'b1;
                            blink_cnt <= '0;
                        end
                    end else if (dec_only) begin
                        level <= sat_dec(level);
                        if (level == LEVEL_ONE) begin
                            state <= EMPTY;
                            empty <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (dec_only) begin
                        level     <= sat_dec(level);
                        state     <= PARTIAL;
                        full      <= 1'b0;
                        blink     <= 1'b0;
                        blink_cnt <= '0;
                    end else begin
                        if (inc_only) begin
                            err <= 1'b1;
                        end
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            blink     <= ~blink;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    level     <= '0;
                    full      <= 1'b0;
                    empty     <= 1'b1;
                    blink     <= 1'b0;
                    blink_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_ctrl.sv
// Randomized and directed bench for level_ctrl with a cycle-level
// behavioural reference model (integer level, full-age based blink).
module tb_level_ctrl;

    localparam int DB = 4;
    localparam int BD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_btn = 1'b0;
    logic       dec_btn = 1'b0;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       err;
    logic       blink;

    always #5 clk = ~clk;

    level_ctrl #(.DB_CYCLES(DB), .BLINK_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_btn (inc_btn),
        .dec_btn (dec_btn),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .err     (err),
        .blink   (blink)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int err_seen = 0;

    // reference model state
    int m_lvl = 0;
    bit m_err = 0;
    int m_age = -1;          // cycles since FULL entry, -1 when not full
    bit m_hist1 [2];         // raw sample one edge ago
    bit m_hist2 [2];         // raw sample two edges ago
    bit m_db [2];
    int m_run [2];
    bit m_pend [2];          // press detected at previous edge

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_btn(input int b, input bit x, output bit ev);
        bit s;
        s = m_hist2[b];
        m_hist2[b] = m_hist1[b];
        m_hist1[b] = x;
        ev = 1'b0;
        if (s != m_db[b]) begin
            m_run[b]++;
            if (m_run[b] == DB) begin
                m_db[b]  = s;
                m_run[b] = 0;
                ev       = s;
            end
        end else begin
            m_run[b] = 0;
        end
    endtask

    task automatic model_edge(input bit i, input bit d, input bit r);
        bit ei, ed;
        if (!r) begin
            m_lvl = 0; m_err = 0; m_age = -1;
            for (int b = 0; b < 2; b++) begin
                m_hist1[b] = 0; m_hist2[b] = 0; m_db[b] = 0; m_run[b] = 0; m_pend[b] = 0;
            end
            return;
        end
        m_err = 0;
        if (m_pend[0] && !m_pend[1]) begin
            if (m_lvl == 7) m_err = 1; else m_lvl++;
        end else if (m_pend[1] && !m_pend[0]) begin
            if (m_lvl == 0) m_err = 1; else m_lvl--;
        end
        if (m_lvl == 7) m_age = (m_age < 0) ? 0 : m_age + 1;
        else m_age = -1;
        model_btn(0, i, ei);
        model_btn(1, d, ed);
        m_pend[0] = ei;
        m_pend[1] = ed;
    endtask

    function automatic int model_outs();
        int bl;
        bl = (m_age >= 0 && ((m_age / BD) % 2) == 0) ? 1 : 0;
        return m_lvl * 16 + ((m_lvl == 7) ? 8 : 0) + ((m_lvl == 0) ? 4 : 0)
               + (m_err ? 2 : 0) + bl;
    endfunction

    task automatic step(input bit i, input bit d, input bit r);
        inc_btn = i;
        dec_btn = d;
        rst_n   = r;
        model_edge(i, d, r);
        @(posedge clk);
        #1;
        check("cycle", int'({level, full, empty, err, blink}), model_outs());
        err_seen += int'(err);
    endtask

    task automatic hold(input bit i, input bit d, input int n, input bit r = 1'b1);
        for (int k = 0; k < n; k++) step(i, d, r);
    endtask

    task automatic do_reset();
        hold(1'b0, 1'b0, 2, 1'b0);
        check("rst_level", int'(level), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full",  int'(full), 0);
        check("rst_err",   int'(err), 0);
        check("rst_blink", int'(blink), 0);
    endtask

    task automatic press(input bit i, input bit d, input int times);
        for (int k = 0; k < times; k++) begin
            hold(i, d, 6);
            hold(1'b0, 1'b0, 8);
        end
    endtask

    bit exp_blink [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int n;
        bit hit;

        // clean single press
        do_reset();
        err_seen = 0;
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 8);
        check("clean_level", int'(level), 1);
        check("clean_empty", int'(empty), 0);
        check("clean_err", err_seen, 0);

        // bouncing press
        do_reset();
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 8);
        check("bounce_level", int'(level), 1);

        // fill to FULL and watch the blink phase from entry
        do_reset();
        press(1'b1, 1'b0, 6);
        check("six_level", int'(level), 6);
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step(1'b1, 1'b0, 1'b1);
            hit = full;
        end
        check("full_reached", int'(hit), 1);
        check("blink_0", int'(blink), int'(exp_blink[0]));
        for (int k = 1; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b1);
            check($sformatf("blink_%0d", k), int'(blink), int'(exp_blink[k]));
        end
        hold(1'b0, 1'b0, 8);
        check("full_level", int'(level), 7);
        err_seen = 0;
        press(1'b1, 1'b0, 1);
        check("over_level", int'(level), 7);
        check("over_err", err_seen, 1);

        // same-cycle inc+dec at 7
        err_seen = 0;
        press(1'b1, 1'b1, 1);
        check("both7_level", int'(level), 7);
        check("both7_err", err_seen, 0);

        // leave FULL: blink drops with full
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step(1'b0, 1'b1, 1'b1);
            hit = !full;
        end
        check("left_full", int'(hit), 1);
        check("leave_level", int'(level), 6);
        check("leave_blink", int'(blink), 0);
        hold(1'b0, 1'b0, 8);

        // underflow at 0 and same-cycle at 0
        do_reset();
        err_seen = 0;
        press(1'b0, 1'b1, 1);
        check("under_level", int'(level), 0);
        check("under_err", err_seen, 1);
        err_seen = 0;
        press(1'b1, 1'b1, 1);
        check("both0_level", int'(level), 0);
        check("both0_err", err_seen, 0);

        // same-cycle at 3
        press(1'b1, 1'b0, 3);
        err_seen = 0;
        press(1'b1, 1'b1, 1);
        check("both3_level", int'(level), 3);
        check("both3_err", err_seen, 0);

        // reset mid-debounce at level 5, button held across release
        press(1'b1, 1'b0, 2);
        check("five_level", int'(level), 5);
        hold(1'b1, 1'b0, 3);
        step(1'b1, 1'b0, 1'b0);
        check("midrst_level", int'(level), 0);
        check("midrst_empty", int'(empty), 1);
        n = 0;
        hit = 0;
        for (int k = 1; k <= 20 && !hit; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (level != 3'd0) begin
                hit = 1;
                n = k;
            end
        end
        check("fresh_latency", n, DB + 3);
        hold(1'b1, 1'b0, 10);
        check("fresh_level", int'(level), 1);
        hold(1'b0, 1'b0, 8);

        // random segments with occasional reset
        for (int s = 0; s < 400; s++) begin
            bit ri, rd, rr;
            int len;
            ri  = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 59) != 0);
            len = rr ? int'($urandom_range(1, 10)) : 1;
            hold(ri, rd, len, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/level_ctrl.md
LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable cycles required before a debounced button changes state; legal range 2..1023.
REQ-002 Parameter BLINK_DIV, default 8: blink half-period in clock cycles; legal range 2..1023.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 inc_btn  input  1  raw "add one" pushbutton, asynchronous to clk, may bounce.
REQ-006 dec_btn  input  1  raw "remove one" pushbutton, asynchronous to clk, may bounce.
REQ-007 level  output  3  current fill level 0..7, MSB first; drives the segment decoder's B, C, D inputs.
REQ-008 full  output  1  high while level = 7.
REQ-009 empty  output  1  high while level = 0.
REQ-010 err  output  1  one-cycle pulse on a rejected overflow or underflow request.
REQ-011 blink  output  1  display blink enable, toggling only while full.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, reset value 0.
REQ-013 The debounced state SHALL take the synchronized value only after that value has differed from the debounced state for DB_CYCLES consecutive cycles; any earlier disagreement-break SHALL restart the count at 0.
REQ-014 A 0->1 change of the debounced state SHALL produce exactly one single-cycle event pulse; 1->0 changes and held buttons SHALL produce no further events.
REQ-015 Level FSM states: EMPTY (level 0), PARTIAL (level 1..6), FULL (level 7).
REQ-016 level, full, empty, err SHALL be registered and SHALL update on the cycle after the event pulse.
REQ-017 inc event alone: EMPTY->PARTIAL (level 1); PARTIAL level+1, to FULL when it reaches 7; in FULL, level held and err pulsed.
REQ-018 dec event alone: FULL->PARTIAL (level 6); PARTIAL level-1, to EMPTY when it reaches 0; in EMPTY, level held and err pulsed.
REQ-019 inc and dec events in the same cycle SHALL leave level and state unchanged and SHALL NOT pulse err, in every state.
REQ-020 Level arithmetic SHALL be 3-bit and saturating; wrap 7->0 or 0->7 SHALL never occur.
REQ-021 full = (state == FULL) and empty = (state == EMPTY), both registered; they SHALL never be high together.
REQ-022 blink SHALL be 0 outside FULL; on entering FULL, the blink counter SHALL clear and blink SHALL start at 1, then invert every BLINK_DIV cycles until FULL is left.
REQ-023 On leaving FULL, blink SHALL be 0 on the same cycle as full falls.

Reset
REQ-024 While rst_n is sampled low: level = 0, state EMPTY, empty = 1, full = 0, err = 0, blink = 0, synchronizers, debounced states and all counters = 0.
REQ-025 Reset asserted mid-debounce or mid-blink SHALL discard all progress; no event SHALL be produced from pre-reset activity.
REQ-026 A button held across reset release SHALL be treated as a fresh press: one inc or dec event DB_CYCLES+2 to DB_CYCLES+3 cycles after release.

Structure
REQ-027 Shared package level_pkg SHALL hold the state typedef (EMPTY, PARTIAL, FULL), LEVEL_W = 3 and LEVEL_MAX = 7.
REQ-028 Sub-module btn_debounce SHALL hold synchronizer, debounce counter and edge detect; level_ctrl SHALL instantiate it twice and contain only the FSM, level register and blink counter.

Verification (bench uses DB_CYCLES = 4, BLINK_DIV = 3)
REQ-029 Clean inc press held 10 cycles from reset -> exactly one event; level 0->1; empty 1->0; err stays 0.
REQ-030 inc_btn bouncing 1,0,1,0 at 1-cycle spacing, then stable high -> single event only after 4 stable cycles; level +1 exactly once.
REQ-031 Eight inc presses from reset -> level 7, full = 1, blink pattern 1,1,1,0,0,0,... from the FULL entry cycle; eighth press -> err one-cycle pulse, level stays 7.
REQ-032 dec press at level 0 -> err pulse, level 0; dec press at level 7 -> level 6, full 0, blink 0 on the same cycle.
REQ-033 inc and dec events in the same cycle at level 3, 0 and 7 -> level unchanged, err 0.
REQ-034 rst_n low for 1 cycle at level 5 mid-debounce -> level 0, empty 1, no event from the interrupted press; button still held -> one event DB_CYCLES+2..+3 cycles after release.
